// File: rtl/uart_boot_loader.sv
// UART boot loader: turns the receiver byte stream into instruction-memory writes.
// Stream format: MAGIC, count[7:0], count[15:8], count little-endian 32-bit words,
// 8-bit additive checksum over the count and data bytes.
// The CPU is held in reset until a load finishes with a matching checksum.
// Optional: define LOADER_TIMEOUT_EN to abort a stalled load to ERROR after
// TIMEOUT_CYCLES clocks without a received byte.
module uart_boot_loader #(
   parameter int unsigned ADDR_W         = 10,
   parameter logic [7:0]  MAGIC          = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_byte,
   input  logic              rx_byte_read,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst_n,
   output logic              load_done,
   output logic              load_err
);

   typedef enum logic [2:0] {StIdle, StLen0, StLen1, StData, StChk, StDone, StError} state_e;

   localparam logic [31:0] MaxWords = 32'd1 << ADDR_W;

   state_e            state_q, state_d;
   logic              sync1_q, sync2_q, prev_q;
   logic              acc;
   logic [15:0]       count_q, count_d;
   logic [7:0]        csum_q, csum_d, csum_add;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [ADDR_W:0]   word_idx_q, word_idx_d;
   logic [23:0]       word_q, word_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              timeout;

   // One accept pulse per rising edge of the synchronized byte-complete level.
   assign acc = sync2_q & ~prev_q;

`ifdef LOADER_TIMEOUT_EN
   logic [31:0] timer_q, timer_d;

   // Inactivity counter: runs only while a load is in progress, cleared by every byte.
   always_comb begin
      timer_d = '0;
      timeout = 1'b0;
      if ((state_q inside {StLen0, StLen1, StData, StChk}) && !acc) begin
         if (timer_q == TIMEOUT_CYCLES - 1) begin
            timeout = 1'b1;
         end else begin
            timer_d = timer_q + 32'd1;
         end
      end
   end

   // Inactivity counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Next-state and datapath: everything advances only on an accepted byte.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      csum_d      = csum_q;
      byte_idx_d  = byte_idx_q;
      word_idx_d  = word_idx_q;
      word_d      = word_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      csum_add    = csum_q + rx_byte;
      unique case (state_q)
         StIdle, StDone, StError: begin
            if (acc && rx_byte == MAGIC) begin
               state_d    = StLen0;
               csum_d     = '0;
               byte_idx_d = '0;
               word_idx_d = '0;
            end
         end
         StLen0: begin
            if (acc) begin
               count_d[7:0] = rx_byte;
               csum_d       = csum_add;
               state_d      = StLen1;
            end
         end
         StLen1: begin
            if (acc) begin
               count_d[15:8] = rx_byte;
               csum_d        = csum_add;
               if (count_d == '0) begin
                  state_d = StChk;
               end else if (32'(count_d) > MaxWords) begin
                  state_d = StError;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (acc) begin
               csum_d     = csum_add;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = {rx_byte, word_q};
                  mem_addr_d  = word_idx_q[ADDR_W-1:0];
                  word_idx_d  = word_idx_q + 1'b1;
                  if (32'(word_idx_d) == 32'(count_q)) begin
                     state_d = StChk;
                  end
               end else begin
                  // Little-endian: bytes enter at the top and drift down.
                  word_d = {rx_byte, word_q[23:8]};
               end
            end
         end
         StChk: begin
            if (acc) begin
               state_d = (rx_byte == csum_q) ? StDone : StError;
            end
         end
         default: state_d = StIdle;
      endcase
      // Timeout only fires without an acc, so no write can be pending here.
      if (timeout) begin
         state_d = StError;
      end
   end

   // State, synchronizer and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         prev_q      <= 1'b0;
         count_q     <= '0;
         csum_q      <= '0;
         byte_idx_q  <= '0;
         word_idx_q  <= '0;
         word_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= rx_byte_read;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         count_q     <= count_d;
         csum_q      <= csum_d;
         byte_idx_q  <= byte_idx_d;
         word_idx_q  <= word_idx_d;
         word_q      <= word_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rst_n = (state_q == StDone);
   assign load_done = (state_q == StDone);
   assign load_err  = (state_q == StError);

endmodule
